// File: rtl/m_digit_serial_adder.sv
// m_digit_serial_adder
//   Digit-serial adder/subtractor. A single DIGIT-bit ripple slice and a
//   registered carry process WIDTH-bit operands over NDIG = WIDTH/DIGIT
//   clock cycles. Results, carry-out and signed overflow are held until
//   the next completion.
//
// Parameters
//   WIDTH   operand/result width; must be a multiple of DIGIT
//   DIGIT   bits processed per clock, 1..WIDTH
//
// Ports
//   w_clk    in   clock, rising edge
//   w_rst    in   asynchronous active-high reset
//   w_start  in   request an operation, sampled only while idle
//   w_sub    in   0 = a+b, 1 = a-b
//   w_a/w_b  in   operands, latched at accept
//   w_busy   out  operation in progress
//   w_done   out  one-cycle pulse when the result registers update
//   w_s      out  result mod 2^WIDTH
//   w_cout   out  carry out of the MSB (subtraction: 1 = no borrow)
//   w_ovf    out  two's-complement overflow
//
// state  | meaning
// S_IDLE | waiting for w_start, result registers hold last completion
// S_RUN  | one digit processed per cycle, NDIG cycles total

module m_digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             w_clk,
  input  logic             w_rst,
  input  logic             w_start,
  input  logic             w_sub,
  input  logic [WIDTH-1:0] w_a,
  input  logic [WIDTH-1:0] w_b,
  output logic             w_busy,
  output logic             w_done,
  output logic [WIDTH-1:0] w_s,
  output logic             w_cout,
  output logic             w_ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;

  // Digit slice: plain ripple of DIGIT full adders.
  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic [DIGIT-1:0] dig_sum;
  logic [DIGIT:0]   c;

  always_comb begin
    dig_a   = a_sh[DIGIT-1:0];
    dig_b   = b_sh[DIGIT-1:0];
    c       = '0;
    dig_sum = '0;
    c[0]    = carry;
    for (int i = 0; i < DIGIT; i++) begin
      dig_sum[i] = dig_a[i] ^ dig_b[i] ^ c[i];
      c[i+1]     = (dig_a[i] & dig_b[i]) | (c[i] & (dig_a[i] ^ dig_b[i]));
    end
  end

  // New digit enters at the MSB end; after NDIG shifts the word is aligned.
  // Cast-and-shift keeps this legal when DIGIT == WIDTH.
  logic [WIDTH-1:0] dig_ext;
  logic [WIDTH-1:0] res_next;
  logic             last;

  always_comb begin
    dig_ext  = WIDTH'(dig_sum);
    res_next = (res >> DIGIT) | (dig_ext << (WIDTH - DIGIT));
    last     = (cnt == CW'(NDIG - 1));
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      w_busy <= 1'b0;
      w_done <= 1'b0;
      w_s    <= '0;
      w_cout <= 1'b0;
      w_ovf  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          w_done <= 1'b0;
          if (w_start) begin
            a_sh   <= w_a;
            b_sh   <= w_sub ? ~w_b : w_b;
            // Subtraction's +1 rides in as the initial carry.
            carry  <= w_sub;
            cnt    <= '0;
            w_busy <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          res   <= res_next;
          carry <= c[DIGIT];
          if (last) begin
            cnt    <= '0;
            w_s    <= res_next;
            w_cout <= c[DIGIT];
            // c[DIGIT-1] is the carry into the MSB only on the last digit.
            w_ovf  <= c[DIGIT-1] ^ c[DIGIT];
            w_done <= 1'b1;
            w_busy <= 1'b0;
            state  <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_digit_serial_adder.sv
// Bench for m_digit_serial_adder: four configurations share one stimulus
// stream; each has an arithmetic reference model compared every cycle.
module tb_m_digit_serial_adder;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        start = 1'b0;
  logic        sub   = 1'b0;
  logic [15:0] a     = '0;
  logic [15:0] b     = '0;

  logic [3:0]  busy_o;
  logic [3:0]  done_o;
  logic [3:0]  cout_o;
  logic [3:0]  ovf_o;
  logic [15:0] s_o [4];

  bit chk_en = 1'b0;
  int n_cmp  = 0;
  int n_bad  = 0;

  always #5 clk = ~clk;

  task automatic check(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Returns {ovf, cout, s} from integer arithmetic on w-bit values.
  function automatic logic [17:0] ref_op(input int w, input logic [15:0] av,
                                         input logic [15:0] bv, input logic sb);
    longint m, x, y, r, sx, sy, t, half;
    logic [15:0] s;
    logic cy, ov;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    x    = longint'(av) & m;
    y    = longint'(bv) & m;
    r    = sb ? x - y : x + y;
    s    = 16'(r & m);
    cy   = sb ? (x >= y) : (x + y > m);
    sx   = (x >= half) ? x - (m + 1) : x;
    sy   = (y >= half) ? y - (m + 1) : y;
    t    = sb ? sx - sy : sx + sy;
    ov   = (t >= half) || (t < -half);
    return {ov, cy, s};
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g
    localparam int W = (gi == 3) ? 8 : 16;
    localparam int D = (gi == 0) ? 4 : (gi == 1) ? 1 : (gi == 2) ? 16 : 2;
    localparam int N = W / D;

    logic [W-1:0] s_w;

    m_digit_serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
      .w_clk  (clk),
      .w_rst  (rst),
      .w_start(start),
      .w_sub  (sub),
      .w_a    (a[W-1:0]),
      .w_b    (b[W-1:0]),
      .w_busy (busy_o[gi]),
      .w_done (done_o[gi]),
      .w_s    (s_w),
      .w_cout (cout_o[gi]),
      .w_ovf  (ovf_o[gi])
    );
    assign s_o[gi] = 16'(s_w);

    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_cout = 1'b0;
    logic        m_ovf  = 1'b0;
    logic [15:0] m_s    = '0;
    logic [17:0] p_res  = '0;
    int          m_left = 0;

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        m_busy = 1'b0; m_done = 1'b0; m_left = 0;
        m_s = '0; m_cout = 1'b0; m_ovf = 1'b0;
      end else begin
        m_done = 1'b0;
        if (m_busy) begin
          m_left--;
          if (m_left == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            {m_ovf, m_cout, m_s} = p_res;
          end
        end else if (start) begin
          p_res  = ref_op(W, a, b, sub);
          m_busy = 1'b1;
          m_left = N;
        end
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        check("busy", gi, 16'(busy_o[gi]), 16'(m_busy));
        check("done", gi, 16'(done_o[gi]), 16'(m_done));
        check("sum",  gi, s_o[gi], m_s);
        check("cout", gi, 16'(cout_o[gi]), 16'(m_cout));
        check("ovf",  gi, 16'(ovf_o[gi]), 16'(m_ovf));
      end
    end
  end

  task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic sb);
    @(posedge clk); #1;
    a = av; b = bv; sub = sb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o != 4'b0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy_o != 4'b0) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout waiting for idle: busy %b required 0000", busy_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic lit(input string nm, input int k, input logic [15:0] es, input logic ec, input logic eo);
    check({nm, "_s"}, k, s_o[k], es);
    check({nm, "_cout"}, k, 16'(cout_o[k]), 16'(ec));
    check({nm, "_ovf"}, k, 16'(ovf_o[k]), 16'(eo));
  endtask

  initial begin
    int nb [4];
    int nd;

    #2 rst = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s", 0, s_o[0], 16'h0000);
    check("rst_busy", 0, 16'(busy_o), 16'h0000);
    rst = 1'b0;

    // 3+4: busy lengths reflect NDIG of each configuration.
    issue(16'd3, 16'd4, 1'b0);
    nb = '{0, 0, 0, 0};
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < 4; k++) nb[k] += int'(busy_o[k]);
      nd += int'(done_o[0]);
      @(posedge clk); #1;
    end
    check("busy_len", 0, 16'(nb[0]), 16'd4);
    check("busy_len", 1, 16'(nb[1]), 16'd16);
    check("busy_len", 2, 16'(nb[2]), 16'd1);
    check("busy_len", 3, 16'(nb[3]), 16'd4);
    check("done_cnt", 0, 16'(nd), 16'd1);
    lit("add3_4", 0, 16'h0007, 1'b0, 1'b0);

    issue(16'hFFFF, 16'h0001, 1'b0); wait_idle();
    lit("ffff_1", 0, 16'h0000, 1'b1, 1'b0);
    issue(16'h7FFF, 16'h0001, 1'b0); wait_idle();
    lit("7fff_1", 0, 16'h8000, 1'b0, 1'b1);
    issue(16'd5, 16'd9, 1'b1); wait_idle();
    lit("5m9", 0, 16'hFFFC, 1'b0, 1'b0);
    issue(16'h8000, 16'h0001, 1'b1); wait_idle();
    lit("8000m1", 0, 16'h7FFF, 1'b1, 1'b1);
    issue(16'h0080, 16'h0080, 1'b0); wait_idle();
    lit("80_80", 3, 16'h0000, 1'b1, 1'b1);
    lit("80_80", 0, 16'h0100, 1'b0, 1'b0);

    // Start while busy is ignored; result holds afterwards.
    issue(16'd1, 16'd2, 1'b0);
    @(posedge clk); #1;
    a = 16'd100; b = 16'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      nd += int'(done_o[0]);
      @(posedge clk); #1;
    end
    check("ign_done_cnt", 0, 16'(nd), 16'd1);
    lit("ign_hold", 0, 16'h0003, 1'b0, 1'b0);

    // Reset in the middle of an operation.
    issue(16'h0010, 16'h0020, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_s", 0, s_o[0], 16'h0000);
    check("mid_rst_busy", 0, 16'(busy_o), 16'h0000);
    check("mid_rst_done", 0, 16'(done_o), 16'h0000);
    check("mid_rst_flags", 0, 16'({cout_o, ovf_o}), 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    issue(16'd8, 16'd9, 1'b0); wait_idle();
    lit("post_rst", 0, 16'd17, 1'b0, 1'b0);

    // Random traffic, including starts while busy and rare resets.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      a     = 16'($urandom);
      b     = 16'($urandom);
      sub   = 1'($urandom_range(0, 1));
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end
    start = 1'b0;
    wait_idle();
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
